// File: rtl/zynet_sequencer_if.sv
// Handshake bundle of the zyNet sequencer: sample source, network load/result and argmax result.
// The master modport is the sequencer side; the slave modport is the surrounding system.
interface zynet_sequencer_if #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned OUTPUT_SIZE = 10
);
    localparam int unsigned CLASS_W = $clog2(OUTPUT_SIZE);

    logic [WORD_SIZE-1:0]             s_data_i;
    logic                             s_valid_i;
    logic                             s_ready_o;
    logic [WORD_SIZE-1:0]             net_data_o;
    logic                             net_valid_o;
    logic                             net_ready_i;
    logic                             net_start_o;
    logic [OUTPUT_SIZE*WORD_SIZE-1:0] net_data_i;
    logic                             net_valid_i;
    logic                             net_yumi_o;
    logic [CLASS_W-1:0]               class_o;
    logic [WORD_SIZE-1:0]             score_o;
    logic                             timeout_o;
    logic                             valid_o;
    logic                             yumi_i;

    modport master (
        input  s_data_i, s_valid_i, net_ready_i, net_data_i, net_valid_i, yumi_i,
        output s_ready_o, net_data_o, net_valid_o, net_start_o, net_yumi_o,
        output class_o, score_o, timeout_o, valid_o
    );

    modport slave (
        output s_data_i, s_valid_i, net_ready_i, net_data_i, net_valid_i, yumi_i,
        input  s_ready_o, net_data_o, net_valid_o, net_start_o, net_yumi_o,
        input  class_o, score_o, timeout_o, valid_o
    );
endinterface

// File: rtl/zynet_sequencer.sv
// Frame sequencer for zyNet: forwards INPUT_LENGTH samples, starts the network, argmaxes its result.
// Optional WAIT watchdog enabled by defining ZYNET_SEQ_TIMEOUT_EN.
module zynet_sequencer #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned INPUT_LENGTH   = 256,
    parameter int unsigned OUTPUT_SIZE    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic go_i,
    output logic busy_o,
    zynet_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(INPUT_LENGTH);
    localparam int unsigned IDX_W = $clog2(OUTPUT_SIZE);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(INPUT_LENGTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(OUTPUT_SIZE - 1);

    if (INPUT_LENGTH < 2 || OUTPUT_SIZE < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("zynet_sequencer: INPUT_LENGTH and OUTPUT_SIZE must be >= 2, TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SCAN, HOLD} state_e;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [OUTPUT_SIZE*WORD_SIZE-1:0] result_q;
    logic [WORD_SIZE-1:0]             best_q;
    logic [IDX_W-1:0]                 best_idx_q;
    logic [WORD_SIZE-1:0]             scan_word;
    logic                             xfer;
`ifdef ZYNET_SEQ_TIMEOUT_EN
    logic [31:0]                      wdog_q;
    logic                             timeout_q;
    logic                             timeout_hit;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        xfer             = 1'b0;
        busy_o           = (state_q != IDLE);
        bus.s_ready_o    = 1'b0;
        bus.net_valid_o  = 1'b0;
        bus.net_start_o  = 1'b0;
        bus.net_yumi_o   = 1'b0;
        bus.valid_o      = 1'b0;
        bus.net_data_o   = bus.s_data_i;
        bus.class_o      = best_idx_q;
        bus.score_o      = best_q;
        scan_word        = result_q[idx_q*WORD_SIZE +: WORD_SIZE];
`ifdef ZYNET_SEQ_TIMEOUT_EN
        timeout_hit      = 1'b0;
        bus.timeout_o    = timeout_q;
`else
        bus.timeout_o    = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (go_i) state_d = LOAD;
            LOAD: begin
                bus.s_ready_o   = bus.net_ready_i;
                bus.net_valid_o = bus.s_valid_i;
                xfer            = bus.s_valid_i & bus.net_ready_i;
                if (xfer && cnt_q == LAST_SAMPLE) state_d = START;
            end
            START: begin
                bus.net_start_o = 1'b1;
                state_d         = WAIT;
            end
            WAIT: begin
                bus.net_yumi_o = bus.net_valid_i;
                // A result arriving on the expiry cycle takes priority over the watchdog.
                if (bus.net_valid_i) state_d = SCAN;
`ifdef ZYNET_SEQ_TIMEOUT_EN
                else if (wdog_q + 32'd1 == TIMEOUT_CYCLES) begin
                    timeout_hit = 1'b1;
                    state_d     = HOLD;
                end
`endif
            end
            SCAN: if (idx_q == LAST_IDX) state_d = HOLD;
            HOLD: begin
                bus.valid_o = 1'b1;
                if (bus.yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            if (state_q == IDLE && go_i) cnt_q <= '0;
            else if (xfer)               cnt_q <= cnt_q + CNT_W'(1);

            if (state_q == WAIT && bus.net_valid_i) begin
                result_q   <= bus.net_data_i;
                best_q     <= bus.net_data_i[WORD_SIZE-1:0];
                best_idx_q <= '0;
                idx_q      <= IDX_W'(1);
            end else if (state_q == SCAN) begin
                // Strict greater-than so ties keep the lower index.
                if ($signed(scan_word) > $signed(best_q)) begin
                    best_q     <= scan_word;
                    best_idx_q <= idx_q;
                end
                idx_q <= idx_q + IDX_W'(1);
            end
`ifdef ZYNET_SEQ_TIMEOUT_EN
            else if (timeout_hit) begin
                best_q     <= '0;
                best_idx_q <= '0;
            end
`endif
        end
    end

`ifdef ZYNET_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == START)     wdog_q <= '0;
            else if (state_q == WAIT) wdog_q <= wdog_q + 32'd1;

            if (state_q == WAIT && bus.net_valid_i) timeout_q <= 1'b0;
            else if (timeout_hit)                   timeout_q <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_zynet_sequencer.sv
// Directed self-checking bench for zynet_sequencer (INPUT_LENGTH=4, OUTPUT_SIZE=4, TIMEOUT_CYCLES=8).
module tb_zynet_sequencer;
    localparam int unsigned IL = 4;

    logic clk_i = 1'b0;
    logic reset_i;
    logic go_i;
    logic busy_o;

    zynet_sequencer_if #(.WORD_SIZE(16), .OUTPUT_SIZE(4)) bus ();

    zynet_sequencer #(
        .WORD_SIZE(16), .INPUT_LENGTH(IL), .OUTPUT_SIZE(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .go_i(go_i), .busy_o(busy_o), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    int unsigned checks = 0;
    int unsigned failures = 0;

    int unsigned xfers = 0, starts = 0, start_xfer = 0;
    int unsigned fx0 = 0, fs0 = 0;
    logic [15:0] got[$];

    always @(posedge clk_i) begin
        if (bus.net_valid_o && bus.net_ready_i) begin
            got.push_back(bus.net_data_o);
            xfers++;
        end
        if (bus.net_start_o) begin
            starts++;
            start_xfer = xfers;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // go pulse then stream `count` samples base, base+1, ...; ends #1 after the START edge when count==IL
    task automatic run_load(input bit bp, input logic [15:0] base, input int unsigned count);
        int unsigned sent = 0;
        int unsigned budget = 0;
        int unsigned errs = 0;
        fx0 = xfers;
        fs0 = starts;
        @(negedge clk_i) go_i = 1'b1;
        @(posedge clk_i) #1 check("go_to_busy", busy_o, 1);
        @(negedge clk_i) go_i = 1'b0;
        while (sent < count && budget < 200) begin
            bus.s_data_i    = base + 16'(sent);
            bus.s_valid_i   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.net_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.s_ready_o !== bus.net_ready_i || bus.net_valid_o !== bus.s_valid_i
                || bus.net_start_o !== 1'b0) errs++;
            @(posedge clk_i);
            if (bus.s_valid_i && bus.net_ready_i) sent++;
            budget++;
            @(negedge clk_i);
        end
        bus.s_valid_i   = 1'b0;
        bus.net_ready_i = 1'b0;
        check("load_budget", sent, count);
        check("load_handshake", errs, 0);
        errs = 0;
        for (int i = 0; i < int'(count); i++) begin
            if (fx0 + i >= got.size() || got[fx0 + i] !== base + 16'(i)) errs++;
        end
        check("sample_order", errs, 0);
        if (count == IL) begin
            check("start_pulse", bus.net_start_o, 1);
            @(posedge clk_i) #1;
            check("start_one_cycle", bus.net_start_o, 0);
            check("start_count", starts - fs0, 1);
            check("start_after_xfers", start_xfer - fx0, IL);
        end
    endtask

    task automatic run_result(input logic [63:0] vec, input logic [1:0] cls, input logic [15:0] score);
        int unsigned n;
        check("wait_no_yumi", bus.net_yumi_o, 0);
        @(negedge clk_i);
        bus.net_data_i  = vec;
        bus.net_valid_i = 1'b1;
        #1 check("yumi_comb", bus.net_yumi_o, 1);
        @(posedge clk_i) #1;
        n = 1;
        check("scan_no_yumi", bus.net_yumi_o, 0);
        @(negedge clk_i);
        bus.net_valid_i = 1'b0;
        bus.net_data_i  = '1;
        while (bus.valid_o !== 1'b1 && n < 50) begin
            @(posedge clk_i) #1;
            n++;
        end
        check("result_latency", n, 4);
        check("class", bus.class_o, cls);
        check("score", bus.score_o, score);
    endtask

    task automatic release_result();
        @(negedge clk_i) bus.yumi_i = 1'b1;
        @(posedge clk_i) #1;
        check("release_valid", bus.valid_o, 0);
        check("release_idle", busy_o, 0);
        @(negedge clk_i) bus.yumi_i = 1'b0;
    endtask

    initial begin
        int unsigned errs;
        int unsigned n;
        reset_i         = 1'b1;
        go_i            = 1'b0;
        bus.s_data_i    = '0;
        bus.s_valid_i   = 1'b0;
        bus.net_ready_i = 1'b0;
        bus.net_data_i  = '0;
        bus.net_valid_i = 1'b0;
        bus.yumi_i      = 1'b0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_s_ready", bus.s_ready_o, 0);
        check("rst_net_valid", bus.net_valid_o, 0);
        check("rst_net_start", bus.net_start_o, 0);
        check("rst_net_yumi", bus.net_yumi_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        check("rst_class", bus.class_o, 0);
        check("rst_score", bus.score_o, 0);
        @(negedge clk_i) reset_i = 1'b0;

        // Frame 1: plain load, positive maximum at index 2
        run_load(1'b0, 16'h1000, IL);
        run_result({16'h0200, 16'h0300, 16'hF000, 16'h0100}, 2'd2, 16'h0300);

        // Output stall with go pulses that must be ignored
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i) go_i = (i % 3 == 0);
            @(posedge clk_i) #1;
            if (bus.valid_o !== 1'b1 || bus.class_o !== 2'd2 || bus.score_o !== 16'h0300
                || busy_o !== 1'b1) errs++;
        end
        check("stall_stable", errs, 0);
        // go in the same cycle as yumi has no effect
        @(negedge clk_i) begin go_i = 1'b1; bus.yumi_i = 1'b1; end
        @(posedge clk_i) #1;
        check("yumi_to_idle", busy_o, 0);
        check("yumi_valid_low", bus.valid_o, 0);
        @(negedge clk_i) begin go_i = 1'b0; bus.yumi_i = 1'b0; end
        @(posedge clk_i) #1 check("go_with_yumi_ignored", busy_o, 0);

        // Frame 2: backpressure, negative scores with a tie
        run_load(1'b1, 16'h2000, IL);
        run_result({16'hD000, 16'hF000, 16'hE000, 16'hF000}, 2'd0, 16'hF000);
        release_result();

        // Reset after two transfers abandons the frame
        run_load(1'b0, 16'h3000, 2);
        bus.s_valid_i   = 1'b1;
        bus.net_ready_i = 1'b1;
        reset_i         = 1'b1;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_s_ready", bus.s_ready_o, 0);
        check("midrst_net_valid", bus.net_valid_o, 0);
        check("midrst_score", bus.score_o, 0);
        check("midrst_class", bus.class_o, 0);
        @(negedge clk_i) begin
            reset_i         = 1'b0;
            bus.s_valid_i   = 1'b0;
            bus.net_ready_i = 1'b0;
        end
        n = starts;
        repeat (5) @(negedge clk_i);
        check("midrst_no_start", starts - n, 0);

        // Frame 3: fresh four transfers, maximum at the last index
        run_load(1'b1, 16'h4000, IL);
        run_result({16'h7FFF, 16'h0001, 16'h0001, 16'h8000}, 2'd3, 16'h7FFF);
        release_result();

`ifdef ZYNET_SEQ_TIMEOUT_EN
        run_load(1'b0, 16'h5000, IL);
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 50) begin
            @(posedge clk_i) #1;
            n++;
        end
        check("timeout_latency", n, 8);
        check("timeout_flag", bus.timeout_o, 1);
        check("timeout_class", bus.class_o, 0);
        check("timeout_score", bus.score_o, 0);
        release_result();
`endif

        // Frame 4: a normal frame leaves timeout_o clear
        run_load(1'b1, 16'h6000, IL);
        run_result({16'h0010, 16'h0050, 16'h0020, 16'hFFFF}, 2'd2, 16'h0050);
        check("timeout_cleared", bus.timeout_o, 0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end
endmodule
